neural_layer_sequencer: RTL and testbench

- Control-side sequencer for the neural accelerator. It merges the control unit, the address generator and the instruction memory into one block.
- It holds a small program of layer descriptors and walks the layers in order.
- For each neuron it issues neuron-RAM read addresses and weight-ROM read addresses, MAC accumulator clears, and neuron-RAM write strobes.
- It sits between the instruction store, the Weight ROM / Neuron RAM, and the MAC core.

---
 rtl/neural_layer_sequencer.sv | 165 ++++++++++++++++
 tb/tb_neural_layer_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/neural_layer_sequencer.sv
// neural_layer_sequencer
//   Control-side sequencer for the neural accelerator. It holds a small
//   program of layer descriptors and walks them in order. For every neuron
//   it issues neuron-RAM and weight-ROM read addresses, clears the MAC
//   accumulator, and strobes the neuron-RAM write once the MAC result has
//   come out of the pipeline.
//
// Ports
//   clk, reset              clock and synchronous active-high reset
//   start                   begin execution (IDLE only)
//   prog_we/addr/data       instruction write port (IDLE only);
//                           data = {n_out[15:8], n_in[7:0]}
//   neuro_read_addr         neuron-RAM read address
//   weight_read_addr        weight-ROM read address
//   read_valid              both read addresses valid, MAC accumulates
//   acc_clear               MAC accumulator clear
//   neuron_finished         pulse on the last input read of a neuron
//   neuro_write_addr        neuron-RAM write address (0 outside WRITE)
//   write_en                neuron-RAM write strobe
//   layer_finished          pulse when a layer completes
//   instruction_pointer     current instruction index
//   busy                    high outside IDLE and HALT
//   done                    high in HALT
module neural_layer_sequencer #(
  parameter int AW         = 8,
  parameter int IMEM_DEPTH = 16,
  parameter int PIPE_LAT   = 2,
  localparam int IPW       = $clog2(IMEM_DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           prog_we,
  input  logic [IPW-1:0] prog_addr,
  input  logic [15:0]    prog_data,
  output logic [AW-1:0]  neuro_read_addr,
  output logic [AW-1:0]  weight_read_addr,
  output logic           read_valid,
  output logic           acc_clear,
  output logic           neuron_finished,
  output logic [AW-1:0]  neuro_write_addr,
  output logic           write_en,
  output logic           layer_finished,
  output logic [IPW-1:0] instruction_pointer,
  output logic           busy,
  output logic           done
);

  localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, RUN, DRAIN, WRITE, NEXT, HALT
  } state_t;

  state_t          state_reg;
  logic [15:0]     imem [IMEM_DEPTH];
  logic [15:0]     instr;
  logic [IPW-1:0]  ip_reg;
  logic [AW-1:0]   rbase_reg, wrbase_reg, wptr_reg;
  logic [AW-1:0]   nra_hold_reg, wra_hold_reg;
  logic [7:0]      i_reg, j_reg, n_in_reg, n_out_reg;
  logic [CW-1:0]   cnt_reg;
  logic            instr_zero;

  // Program store: contents survive reset; only writable while idle.
  always_ff @(posedge clk) begin
    if (prog_we && state_reg == IDLE)
      imem[prog_addr] <= prog_data;
  end

  assign instr      = imem[ip_reg];
  assign instr_zero = (instr[7:0] == 8'd0) || (instr[15:8] == 8'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      ip_reg       <= '0;
      rbase_reg    <= '0;
      wrbase_reg   <= '0;
      wptr_reg     <= '0;
      nra_hold_reg <= '0;
      wra_hold_reg <= '0;
      i_reg        <= '0;
      j_reg        <= '0;
      n_in_reg     <= '0;
      n_out_reg    <= '0;
      cnt_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= FETCH;
            ip_reg    <= '0;
            rbase_reg <= '0;
            wptr_reg  <= '0;
          end
        end
        FETCH: begin
          n_in_reg  <= instr[7:0];
          n_out_reg <= instr[15:8];
          if (instr_zero) begin
            state_reg <= HALT;
          end else begin
            wrbase_reg <= rbase_reg + AW'(instr[7:0]);
            i_reg      <= '0;
            j_reg      <= '0;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          // Remember the issued addresses so they hold outside RUN.
          nra_hold_reg <= rbase_reg + AW'(i_reg);
          wra_hold_reg <= wptr_reg;
          i_reg        <= i_reg + 8'd1;
          wptr_reg     <= wptr_reg + 1'b1;
          if (i_reg == n_in_reg - 8'd1) begin
            cnt_reg   <= '0;
            state_reg <= (PIPE_LAT == 0) ? WRITE : DRAIN;
          end
        end
        DRAIN: begin
          if (cnt_reg == CW'(PIPE_LAT - 1))
            state_reg <= WRITE;
          else
            cnt_reg <= cnt_reg + 1'b1;
        end
        WRITE: begin
          if (j_reg < n_out_reg - 8'd1) begin
            j_reg     <= j_reg + 8'd1;
            i_reg     <= '0;
            state_reg <= RUN;
          end else begin
            state_reg <= NEXT;
          end
        end
        NEXT: begin
          // This layer's outputs become the next layer's inputs.
          rbase_reg <= wrbase_reg;
          if (ip_reg == IPW'(IMEM_DEPTH - 1)) begin
            state_reg <= HALT;
          end else begin
            ip_reg    <= ip_reg + 1'b1;
            state_reg <= FETCH;
          end
        end
        HALT:    state_reg <= HALT;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Strobes and addresses decode directly from registered state.
  assign read_valid          = (state_reg == RUN);
  assign neuro_read_addr     = read_valid ? rbase_reg + AW'(i_reg) : nra_hold_reg;
  assign weight_read_addr    = read_valid ? wptr_reg : wra_hold_reg;
  assign neuron_finished     = read_valid && (i_reg == n_in_reg - 8'd1);
  assign write_en            = (state_reg == WRITE);
  assign neuro_write_addr    = write_en ? wrbase_reg + AW'(j_reg) : '0;
  assign acc_clear           = write_en || (state_reg == FETCH && !instr_zero);
  assign layer_finished      = (state_reg == NEXT);
  assign instruction_pointer = ip_reg;
  assign done                = (state_reg == HALT);
  assign busy                = (state_reg != IDLE) && (state_reg != HALT);

endmodule

// File: tb/tb_neural_layer_sequencer.sv
module tb_neural_layer_sequencer;

  localparam int AW = 8;
  localparam int IMEM_DEPTH = 16;
  localparam int PIPE_LAT = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          prog_we = 1'b0;
  logic [3:0]    prog_addr = '0;
  logic [15:0]   prog_data = '0;
  logic [AW-1:0] neuro_read_addr, weight_read_addr, neuro_write_addr;
  logic          read_valid, acc_clear, neuron_finished, write_en;
  logic          layer_finished, busy, done;
  logic [3:0]    instruction_pointer;

  neural_layer_sequencer #(.AW(AW), .IMEM_DEPTH(IMEM_DEPTH), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .neuro_read_addr(neuro_read_addr), .weight_read_addr(weight_read_addr),
    .read_valid(read_valid), .acc_clear(acc_clear),
    .neuron_finished(neuron_finished), .neuro_write_addr(neuro_write_addr),
    .write_en(write_en), .layer_finished(layer_finished),
    .instruction_pointer(instruction_pointer), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Activity log gathered on the falling edge.
  int nr_q[$];
  int wr_q[$];
  int wa_q[$];
  int lf_cnt;
  int fetch_cyc, we_cyc, nf_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (read_valid) begin
        nr_q.push_back(int'(neuro_read_addr));
        wr_q.push_back(int'(weight_read_addr));
      end
      if (write_en) wa_q.push_back(int'(neuro_write_addr));
      if (layer_finished) lf_cnt++;
      if (busy && acc_clear && !write_en && fetch_cyc < 0) fetch_cyc = cyc;
      if (write_en && we_cyc < 0) we_cyc = cyc;
      if (neuron_finished && nf_cyc < 0) nf_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      $display("ok   %s: %0h", tag, act);
    end
  endtask

  task automatic clear_log();
    nr_q.delete(); wr_q.delete(); wa_q.delete();
    lf_cnt = 0; fetch_cyc = -1; we_cyc = -1; nf_cyc = -1;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); @(negedge clk); reset = 1'b0;
    clear_log();
  endtask

  task automatic prog(input logic [3:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("wait_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_nra"}, 32'(neuro_read_addr), 32'd0);
    check({pfx, "_wra"}, 32'(weight_read_addr), 32'd0);
    check({pfx, "_nwa"}, 32'(neuro_write_addr), 32'd0);
    check({pfx, "_strobes"},
          {26'd0, read_valid, acc_clear, neuron_finished, write_en, layer_finished, busy}, 32'd0);
    check({pfx, "_done"}, 32'(done), 32'd0);
    check({pfx, "_ip"}, 32'(instruction_pointer), 32'd0);
  endtask

  // Expected activity of program {0x0203, 0x0102, 0x0000}.
  task automatic verify_two_layer(input string pfx);
    int exp_nr[8] = '{0, 1, 2, 0, 1, 2, 3, 4};
    int exp_wa[3] = '{3, 4, 5};
    check({pfx, "_nreads"}, 32'(nr_q.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_nra%0d", pfx, k), (k < nr_q.size()) ? 32'(nr_q[k]) : 32'hFFFF, 32'(exp_nr[k]));
      check($sformatf("%s_wra%0d", pfx, k), (k < wr_q.size()) ? 32'(wr_q[k]) : 32'hFFFF, 32'(k));
    end
    check({pfx, "_nwrites"}, 32'(wa_q.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      check($sformatf("%s_nwa%0d", pfx, k), (k < wa_q.size()) ? 32'(wa_q[k]) : 32'hFFFF, 32'(exp_wa[k]));
    check({pfx, "_layers"}, 32'(lf_cnt), 32'd2);
    check({pfx, "_done"}, 32'(done), 32'd1);
    check({pfx, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    clear_log();

    // Reset state.
    do_reset();
    check_outputs_zero("reset");

    // Two-layer program.
    prog(4'd0, 16'h0203);
    prog(4'd1, 16'h0102);
    prog(4'd2, 16'h0000);
    pulse_start();
    wait_done(200);
    verify_two_layer("prog2");
    check("hold_nra", 32'(neuro_read_addr), 32'd4);
    check("hold_wra", 32'(weight_read_addr), 32'd7);
    check("halt_nwa", 32'(neuro_write_addr), 32'd0);
    pulse_start();
    check("halt_ignores_start", 32'(done), 32'd1);

    // Timing of a single 1x3 layer; write attempt while busy must be ignored.
    do_reset();
    prog(4'd0, 16'h0103);
    prog(4'd1, 16'h0000);
    pulse_start();
    prog(4'd1, 16'h0101);
    wait_done(200);
    check("t_we_after_fetch", 32'(we_cyc - fetch_cyc), 32'd6);
    check("t_nf_before_write", 32'(we_cyc - nf_cyc), 32'd3);
    check("guard_layers", 32'(lf_cnt), 32'd1);
    check("guard_nwrites", 32'(wa_q.size()), 32'd1);

    // Mid-run reset, then an identical rerun.
    do_reset();
    prog(4'd0, 16'h0203);
    prog(4'd1, 16'h0102);
    prog(4'd2, 16'h0000);
    pulse_start();
    n = 0;
    while (!(read_valid && weight_read_addr == 8'd1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("midrun_reached_run", 32'(read_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("midrun");
    reset = 1'b0;
    clear_log();
    pulse_start();
    wait_done(200);
    verify_two_layer("rerun");

    // Zero-input layer halts straight from FETCH.
    do_reset();
    prog(4'd0, 16'h0500);
    pulse_start();
    check("zero_fetch_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("zero_halt", 32'(done), 32'd1);
    check("zero_reads", 32'(nr_q.size()), 32'd0);
    check("zero_layers", 32'(lf_cnt), 32'd0);

    // Full program of 1x1 layers.
    do_reset();
    for (int k = 0; k < IMEM_DEPTH; k++) prog(4'(k), 16'h0101);
    pulse_start();
    wait_done(500);
    check("full_layers", 32'(lf_cnt), 32'(IMEM_DEPTH));
    check("full_ip", 32'(instruction_pointer), 32'(IMEM_DEPTH - 1));
    check("full_nwrites", 32'(wa_q.size()), 32'(IMEM_DEPTH));
    check("full_last_nwa", (wa_q.size() > 0) ? 32'(wa_q[wa_q.size()-1]) : 32'hFFFF, 32'(IMEM_DEPTH));
    check("full_last_nra", (nr_q.size() > 0) ? 32'(nr_q[nr_q.size()-1]) : 32'hFFFF, 32'(IMEM_DEPTH - 1));
    check("full_last_wra", (wr_q.size() > 0) ? 32'(wr_q[wr_q.size()-1]) : 32'hFFFF, 32'(IMEM_DEPTH - 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
